// File: rtl/de1_soc_qsys_cpu_oci_dct_packer_if.sv
// Trace bus between the DCT packer and its neighbours.
// Atom side:  atm_valid / atm_data in, atm_ready out (from the packer's view).
// Word side:  dct_buffer / dct_count / dct_valid out, dct_ready in.
// modport master: the packer (drives atm_ready and the dct_* word).
// modport slave : the CPU debug core / trace sink pair (drives atoms and dct_ready).
interface de1_soc_qsys_cpu_oci_dct_packer_if #(
    parameter int unsigned SYM_W    = 2,
    parameter int unsigned MAX_SYMS = 15
);
    localparam int unsigned DCT_W = SYM_W * MAX_SYMS;
    localparam int unsigned CNT_W = 4;

    logic             atm_valid;
    logic [SYM_W-1:0] atm_data;
    logic             atm_ready;
    logic [DCT_W-1:0] dct_buffer;
    logic [CNT_W-1:0] dct_count;
    logic             dct_valid;
    logic             dct_ready;

    modport master (
        input  atm_valid, atm_data, dct_ready,
        output atm_ready, dct_buffer, dct_count, dct_valid
    );

    modport slave (
        output atm_valid, atm_data, dct_ready,
        input  atm_ready, dct_buffer, dct_count, dct_valid
    );
endinterface

// File: rtl/de1_soc_qsys_cpu_oci_dct_packer.sv
// OCI direct-trace packer: packs 2-bit trace atoms into 30-bit DCT words
// (oldest atom in the LSBs) with a 4-bit atom count, hands them to the trace
// sink over valid/ready, and runs the end-of-test flush.
// Ports:
//   clk, reset      - rising-edge clock, asynchronous active-high reset
//   trc (master)    - atom input handshake and DCT word output handshake
//   end_req         - end-of-test request (level, honoured only in RUN)
//   test_ending     - flush in progress or done
//   test_has_ended  - flush complete, sticky until reset
//   trace_overflow  - sticky atom-drop flag
// Optional feature macro: DCT_DROP_ON_FULL_EN
//   defined   - atm_ready is held high in RUN; atoms arriving while the
//               accumulator is full and the output slot is busy are dropped
//               and trace_overflow is set.
//   undefined - full accumulator backpressures the atom source;
//               trace_overflow is constant 0.
module de1_soc_qsys_cpu_oci_dct_packer #(
    parameter int unsigned SYM_W    = 2,
    parameter int unsigned MAX_SYMS = 15
) (
    input  logic clk,
    input  logic reset,
    de1_soc_qsys_cpu_oci_dct_packer_if.master trc,
    input  logic end_req,
    output logic test_ending,
    output logic test_has_ended,
    output logic trace_overflow
);
    localparam int unsigned DCT_W = SYM_W * MAX_SYMS;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned SH_W  = $clog2(DCT_W);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2,
        ENDED = 2'd3
    } state_t;

    state_t           state;
    logic [DCT_W-1:0] acc;
    logic [CNT_W-1:0] acc_cnt;
    logic [DCT_W-1:0] dct_buffer_q;
    logic [CNT_W-1:0] dct_count_q;
    logic             dct_valid_q;

    logic             slot_free;
    logic             acc_full;
    logic             blocked;
    logic             launch;
    logic             accept;
    logic [DCT_W-1:0] acc_base;
    logic [CNT_W-1:0] cnt_base;
    logic [SH_W-1:0]  wr_sh;
    logic [DCT_W-1:0] acc_next;

    // Output slot can take a new word this cycle, including same-cycle reload.
    assign slot_free = !dct_valid_q || trc.dct_ready;
    assign acc_full  = (acc_cnt == CNT_W'(MAX_SYMS));
    assign blocked   = acc_full && !slot_free;

    // Full words leave in RUN; a partial word leaves once when flushing.
    assign launch = slot_free &&
                    ((state == RUN   && acc_full) ||
                     (state == FLUSH && acc_cnt != '0));

`ifdef DCT_DROP_ON_FULL_EN
    assign trc.atm_ready = (state == RUN);
    assign accept        = trc.atm_valid && (state == RUN) && !blocked;
`else
    assign trc.atm_ready = (state == RUN) && !blocked;
    assign accept        = trc.atm_valid && trc.atm_ready;
`endif

    // A launch empties the accumulator first, so a same-cycle atom lands at slot 0.
    assign acc_base = launch ? '0 : acc;
    assign cnt_base = launch ? '0 : acc_cnt;
    assign wr_sh    = SH_W'(cnt_base * SYM_W);
    assign acc_next = acc_base | (DCT_W'(trc.atm_data) << wr_sh);

    // Accumulator, output register and flush FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            acc          <= '0;
            acc_cnt      <= '0;
            dct_buffer_q <= '0;
            dct_count_q  <= '0;
            dct_valid_q  <= 1'b0;
        end else begin
            if (accept) begin
                acc     <= acc_next;
                acc_cnt <= cnt_base + CNT_W'(1);
            end else if (launch) begin
                acc     <= '0;
                acc_cnt <= '0;
            end

            if (launch) begin
                dct_buffer_q <= acc;
                dct_count_q  <= acc_cnt;
                dct_valid_q  <= 1'b1;
            end else if (trc.dct_ready) begin
                dct_valid_q  <= 1'b0;
            end

            case (state)
                RUN: begin
                    if (end_req) state <= FLUSH;
                end
                FLUSH: begin
                    // Empty accumulator skips the launch; otherwise wait for the slot.
                    if (acc_cnt == '0 || slot_free) state <= DRAIN;
                end
                DRAIN: begin
                    if (slot_free) state <= ENDED;
                end
                ENDED: begin
                    state <= ENDED;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

`ifdef DCT_DROP_ON_FULL_EN
    logic overflow_q;

    // Sticky record that an offered atom was discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (state == RUN && trc.atm_valid && blocked) begin
            overflow_q <= 1'b1;
        end
    end

    assign trace_overflow = overflow_q;
`else
    assign trace_overflow = 1'b0;
`endif

    assign trc.dct_buffer = dct_buffer_q;
    assign trc.dct_count  = dct_count_q;
    assign trc.dct_valid  = dct_valid_q;

    // Status flags decode straight from the state register.
    assign test_ending    = (state != RUN);
    assign test_has_ended = (state == ENDED);
endmodule

// File: tb/tb_de1_soc_qsys_cpu_oci_dct_packer.sv
module tb_de1_soc_qsys_cpu_oci_dct_packer;
    logic clk = 1'b0;
    logic reset;
    logic end_req;
    logic test_ending;
    logic test_has_ended;
    logic trace_overflow;

    always #5 clk = ~clk;

    de1_soc_qsys_cpu_oci_dct_packer_if bus ();

    de1_soc_qsys_cpu_oci_dct_packer u_dut (
        .clk            (clk),
        .reset          (reset),
        .trc            (bus.master),
        .end_req        (end_req),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .trace_overflow (trace_overflow)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every word the sink accepts, as {count, buffer}.
    logic [33:0] words[$];
    always @(posedge clk) begin
        if (!reset && bus.dct_valid && bus.dct_ready)
            words.push_back({bus.dct_count, bus.dct_buffer});
    end

    // A stalled word must stay valid and unchanged until the sink takes it.
    logic        prev_hold;
    logic [29:0] prev_buf;
    logic [3:0]  prev_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_hold <= 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 32'(bus.dct_valid), 32'd1);
                chk("hold_buffer", 32'(bus.dct_buffer), 32'(prev_buf));
                chk("hold_count", 32'(bus.dct_count), 32'(prev_cnt));
            end
            prev_hold <= bus.dct_valid && !bus.dct_ready;
            prev_buf  <= bus.dct_buffer;
            prev_cnt  <= bus.dct_count;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic sink_rdy);
        reset         = 1'b1;
        end_req       = 1'b0;
        bus.atm_valid = 1'b0;
        bus.atm_data  = 2'd0;
        bus.dct_ready = sink_rdy;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        words.delete();
    endtask

    // Offer one atom for one cycle; ok reports whether it was accepted.
    task automatic feed(input logic [1:0] a, output bit ok);
        bus.atm_valid = 1'b1;
        bus.atm_data  = a;
        @(negedge clk);
        ok = bus.atm_ready;
        step();
        bus.atm_valid = 1'b0;
    endtask

    task automatic do_flush();
        end_req = 1'b1;
        step();
        end_req = 1'b0;
    endtask

    task automatic wait_ended(input int budget, input string name);
        for (int i = 0; i < budget && !test_has_ended; i++) step();
        chk(name, 32'(test_has_ended), 32'd1);
    endtask

    task automatic wait_words(input int n, input int budget);
        for (int i = 0; i < budget && words.size() < n; i++) step();
    endtask

    function automatic logic [1:0] atom_of(input int start, input int stp, input int k);
        return 2'((start + k * stp) % 4);
    endfunction

    typedef struct {
        int          n;
        int          start;
        int          stp;
        bit          flush;
        logic [29:0] exp_buf;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t vt[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        int          stall;
        logic [29:0] w;
        logic [1:0]  t2[40];
        logic [29:0] t2_exp[3];
        int          first_stall;
        int          acc_n;
        int          cyc;

        vt[0] = '{15, 0, 1, 1'b0, 30'h24E4E4E4, 4'd15};
        vt[1] = '{5,  3, 0, 1'b1, 30'h000003FF, 4'd5};
        vt[2] = '{1,  2, 0, 1'b1, 30'h00000002, 4'd1};
        vt[3] = '{14, 1, 0, 1'b1, 30'h05555555, 4'd14};
        vt[4] = '{6,  3, 3, 1'b1, 30'h00000B1B, 4'd6};
        vt[5] = '{9,  1, 2, 1'b1, 30'h0001DDDD, 4'd9};

        // Reset state
        do_reset(1'b1);
        chk("rst_atm_ready", 32'(bus.atm_ready), 32'd1);
        chk("rst_dct_valid", 32'(bus.dct_valid), 32'd0);
        chk("rst_dct_count", 32'(bus.dct_count), 32'd0);
        chk("rst_dct_buffer", 32'(bus.dct_buffer), 32'd0);
        chk("rst_test_ending", 32'(test_ending), 32'd0);
        chk("rst_test_has_ended", 32'(test_has_ended), 32'd0);
        chk("rst_trace_overflow", 32'(trace_overflow), 32'd0);

        // Table: full word with ready sink, and partial words by flush
        foreach (vt[v]) begin
            do_reset(1'b1);
            stall = 0;
            for (int k = 0; k < vt[v].n; k++) begin
                feed(atom_of(vt[v].start, vt[v].stp, k), ok);
                if (!ok) stall++;
            end
            chk($sformatf("v%0d_no_stall", v), 32'(stall), 32'd0);
            if (vt[v].flush) begin
                do_flush();
                chk($sformatf("v%0d_ending", v), 32'(test_ending), 32'd1);
                chk($sformatf("v%0d_not_ended_yet", v), 32'(test_has_ended), 32'd0);
                wait_ended(10, $sformatf("v%0d_ended", v));
            end else begin
                wait_words(1, 10);
            end
            chk($sformatf("v%0d_nwords", v), 32'(words.size()), 32'd1);
            if (words.size() > 0) begin
                w = words[0][29:0];
                chk($sformatf("v%0d_buffer", v), 32'(w), 32'(vt[v].exp_buf));
                chk($sformatf("v%0d_count", v), 32'(words[0][33:30]), 32'(vt[v].exp_cnt));
                for (int s = 0; s < 15; s++)
                    chk($sformatf("v%0d_slot%0d", v, s), 32'(w[2*s +: 2]),
                        (s < vt[v].n) ? 32'(atom_of(vt[v].start, vt[v].stp, s)) : 32'd0);
            end
        end

`ifndef DCT_DROP_ON_FULL_EN
        // Stalled sink: 40 atoms, sink ready from cycle 50
        for (int i = 0; i < 40; i++) t2[i] = 2'((i * 3 + 1) % 4);
        for (int j = 0; j < 3; j++) t2_exp[j] = '0;
        for (int i = 0; i < 40; i++) t2_exp[i / 15] = t2_exp[i / 15] | (30'(t2[i]) << (2 * (i % 15)));
        do_reset(1'b0);
        first_stall = -1;
        acc_n = 0;
        cyc = 0;
        while (acc_n < 40 && cyc < 200) begin
            bus.dct_ready = (cyc >= 50);
            bus.atm_valid = 1'b1;
            bus.atm_data  = t2[acc_n];
            @(negedge clk);
            ok = bus.atm_ready;
            if (!ok && first_stall < 0) first_stall = acc_n;
            step();
            if (ok) acc_n++;
            cyc++;
        end
        bus.atm_valid = 1'b0;
        chk("t2_first_stall", 32'(first_stall), 32'd30);
        chk("t2_accepted", 32'(acc_n), 32'd40);
        chk("t2_overflow", 32'(trace_overflow), 32'd0);
        do_flush();
        wait_ended(20, "t2_ended");
        chk("t2_nwords", 32'(words.size()), 32'd3);
        for (int j = 0; j < 3 && j < words.size(); j++) begin
            chk($sformatf("t2_w%0d_buffer", j), 32'(words[j][29:0]), 32'(t2_exp[j]));
            chk($sformatf("t2_w%0d_count", j), 32'(words[j][33:30]), (j == 2) ? 32'd10 : 32'd15);
        end
`else
        // Drop mode: stalled sink, 31 atoms, the 31st is dropped
        do_reset(1'b0);
        stall = 0;
        for (int k = 0; k < 31; k++) begin
            if (k == 30) chk("t6_no_overflow_yet", 32'(trace_overflow), 32'd0);
            feed(2'd1, ok);
            if (!ok) stall++;
        end
        chk("t6_never_stalled", 32'(stall), 32'd0);
        chk("t6_overflow", 32'(trace_overflow), 32'd1);
        bus.dct_ready = 1'b1;
        wait_words(2, 10);
        chk("t6_nwords", 32'(words.size()), 32'd2);
        chk("t6_overflow_sticky", 32'(trace_overflow), 32'd1);
`endif

        // Flush with nothing buffered
        do_reset(1'b1);
        do_flush();
        wait_ended(2, "t4_ended");
        chk("t4_ending", 32'(test_ending), 32'd1);
        feed(2'd3, ok);
        chk("t4_atom_refused", 32'(ok), 32'd0);
        repeat (3) step();
        chk("t4_no_words", 32'(words.size()), 32'd0);
        chk("t4_no_valid", 32'(bus.dct_valid), 32'd0);

        // Reset with a word pending, then a fresh stream
        do_reset(1'b0);
        for (int k = 0; k < 15; k++) feed(2'd2, ok);
        step();
        chk("t5_pending", 32'(bus.dct_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_async_valid", 32'(bus.dct_valid), 32'd0);
        chk("t5_async_buffer", 32'(bus.dct_buffer), 32'd0);
        chk("t5_async_ready", 32'(bus.atm_ready), 32'd1);
        step();
        reset = 1'b0;
        bus.dct_ready = 1'b1;
        feed(2'd1, ok);
        feed(2'd2, ok);
        feed(2'd3, ok);
        do_flush();
        wait_ended(10, "t5_ended");
        chk("t5_nwords", 32'(words.size()), 32'd1);
        if (words.size() > 0) begin
            chk("t5_buffer", 32'(words[0][29:0]), 32'h39);
            chk("t5_count", 32'(words[0][33:30]), 32'd3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
